// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
// Reset and lock sequencer for the system PLL. Runs on the free-running PLL
// reference clock, pulses the PLL reset, qualifies the (asynchronous) PLL lock
// indication, holds the core in reset until lock has been stable, retries
// failed lock attempts and reports lock status.
//
// Build option:
//   PLL_LOCK_AUTO_RELOCK_EN  defined   : lock loss in RUN restarts the sequence
//                                        with a fresh retry budget.
//                            undefined : lock loss in RUN parks in FAIL until
//                                        relock_req or reset_n.
//
// Ports:
//   refclk      in   PLL reference clock, the only clock of this block
//   reset_n     in   asynchronous active-low reset
//   extlock     in   raw PLL lock, asynchronous to refclk
//   relock_req  in   single-cycle request to restart the whole sequence
//   pll_reset   out  active-high PLL reset
//   sys_rst_n   out  active-low core reset, synchronous to refclk
//   lock_ok     out  high while in RUN
//   lock_fail   out  high while in FAIL
//   retry_cnt   out  lock retries used in the current sequence
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_STABLE   = 1024,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int SYS_RST_DELAY = 16,
   parameter int MAX_RETRY     = 3
) (
   input  logic       refclk,
   input  logic       reset_n,
   input  logic       extlock,
   input  logic       relock_req,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       lock_ok,
   output logic       lock_fail,
   output logic [3:0] retry_cnt
);

   localparam int RST_W = $clog2(RST_CYCLES) + 1;
   localparam int STB_W = $clog2(LOCK_STABLE) + 1;
   localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
   localparam int REL_W = $clog2(SYS_RST_DELAY) + 1;

   // RESET and timeout compare against the last cycle so the state lasts
   // exactly N cycles; stable and release compare against the reached count,
   // which together with the output register gives the documented latency.
   localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
   localparam logic [RST_W-1:0] RST_ONE   = RST_W'(1);
   localparam logic [STB_W-1:0] STB_DONE  = STB_W'(LOCK_STABLE);
   localparam logic [STB_W-1:0] STB_ONE   = STB_W'(1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
   localparam logic [REL_W-1:0] REL_DONE  = REL_W'(SYS_RST_DELAY);
   localparam logic [REL_W-1:0] REL_ONE   = REL_W'(1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t           state_r, state_next;
   logic [1:0]       sync_r;
   logic             lock_s;
   logic [RST_W-1:0] rst_cnt_r, rst_cnt_next;
   logic [STB_W-1:0] stb_cnt_r, stb_cnt_next;
   logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_next;
   logic [REL_W-1:0] rel_cnt_r, rel_cnt_next;
   logic [3:0]       retry_r, retry_next;
   logic             pll_reset_s, sys_rst_n_s, lock_ok_s, lock_fail_s;
   logic             pll_reset_r, sys_rst_n_r, lock_ok_r, lock_fail_r;

   assign lock_s = sync_r[1];

   // Two-flop synchronizer for the asynchronous lock indication.
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], extlock};
      end
   end

   // Next state, retry count and counters. Counters default to zero, so they
   // only keep counting while the state holds and are cleared on every entry.
   always_comb begin
      state_next   = state_r;
      retry_next   = retry_r;
      rst_cnt_next = '0;
      stb_cnt_next = '0;
      tmo_cnt_next = '0;
      rel_cnt_next = '0;
      if (relock_req) begin
         state_next = ST_RESET;
         retry_next = 4'd0;
      end else begin
         case (state_r)
            ST_RESET: begin
               if (rst_cnt_r == RST_LAST) begin
                  state_next = ST_WAIT_LOCK;
               end else begin
                  rst_cnt_next = rst_cnt_r + RST_ONE;
               end
            end
            ST_WAIT_LOCK: begin
               // Lock acceptance wins over a timeout in the same cycle.
               if (stb_cnt_r == STB_DONE) begin
                  state_next = ST_RELEASE;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  if (retry_r < RETRY_MAX) begin
                     retry_next = retry_r + 4'd1;
                     state_next = ST_RESET;
                  end else begin
                     state_next = ST_FAIL;
                  end
               end else begin
                  // A lock glitch restarts only the stable count.
                  tmo_cnt_next = tmo_cnt_r + TMO_ONE;
                  if (lock_s) begin
                     stb_cnt_next = stb_cnt_r + STB_ONE;
                  end else begin
                     stb_cnt_next = '0;
                  end
               end
            end
            ST_RELEASE: begin
               if (!lock_s) begin
                  state_next = ST_RESET;
               end else if (rel_cnt_r == REL_DONE) begin
                  state_next = ST_RUN;
               end else begin
                  rel_cnt_next = rel_cnt_r + REL_ONE;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
`ifdef PLL_LOCK_AUTO_RELOCK_EN
                  state_next = ST_RESET;
                  retry_next = 4'd0;
`else
                  state_next = ST_FAIL;
`endif
               end else begin
                  state_next = ST_RUN;
               end
            end
            ST_FAIL: begin
               state_next = ST_FAIL;
            end
            default: begin
               state_next = ST_RESET;
               retry_next = 4'd0;
            end
         endcase
      end
   end

   // State, counter and retry registers.
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_RESET;
         rst_cnt_r <= '0;
         stb_cnt_r <= '0;
         tmo_cnt_r <= '0;
         rel_cnt_r <= '0;
         retry_r   <= 4'd0;
      end else begin
         state_r   <= state_next;
         rst_cnt_r <= rst_cnt_next;
         stb_cnt_r <= stb_cnt_next;
         tmo_cnt_r <= tmo_cnt_next;
         rel_cnt_r <= rel_cnt_next;
         retry_r   <= retry_next;
      end
   end

   // Output decode; registering it from the next state keeps every output a
   // flop whose value always equals the decode of the current state.
   always_comb begin
      pll_reset_s = 1'b1;
      sys_rst_n_s = 1'b0;
      lock_ok_s   = 1'b0;
      lock_fail_s = 1'b0;
      case (state_next)
         ST_RESET: begin
            pll_reset_s = 1'b1;
         end
         ST_WAIT_LOCK, ST_RELEASE: begin
            pll_reset_s = 1'b0;
         end
         ST_RUN: begin
            pll_reset_s = 1'b0;
            sys_rst_n_s = 1'b1;
            lock_ok_s   = 1'b1;
         end
         ST_FAIL: begin
            pll_reset_s = 1'b1;
            lock_fail_s = 1'b1;
         end
         default: begin
            pll_reset_s = 1'b1;
         end
      endcase
   end

   // Output registers; reset_n forces the safe values without a clock.
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         pll_reset_r <= 1'b1;
         sys_rst_n_r <= 1'b0;
         lock_ok_r   <= 1'b0;
         lock_fail_r <= 1'b0;
      end else begin
         pll_reset_r <= pll_reset_s;
         sys_rst_n_r <= sys_rst_n_s;
         lock_ok_r   <= lock_ok_s;
         lock_fail_r <= lock_fail_s;
      end
   end

   assign pll_reset = pll_reset_r;
   assign sys_rst_n = sys_rst_n_r;
   assign lock_ok   = lock_ok_r;
   assign lock_fail = lock_fail_r;
   assign retry_cnt = retry_r;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_ctrl
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_STABLE=8,
// LOCK_TIMEOUT=32, SYS_RST_DELAY=4, MAX_RETRY=2. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point; expected
// cycle counts are worked out by hand in the comments.
// -----------------------------------------------------------------------------
module tb_pll_lock_ctrl;

   logic       refclk = 1'b0;
   logic       reset_n;
   logic       extlock;
   logic       relock_req;
   logic       pll_reset;
   logic       sys_rst_n;
   logic       lock_ok;
   logic       lock_fail;
   logic [3:0] retry_cnt;

   int checks   = 0;
   int failures = 0;
   int n;

   pll_lock_ctrl #(
      .RST_CYCLES   (4),
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (32),
      .SYS_RST_DELAY(4),
      .MAX_RETRY    (2)
   ) dut (
      .refclk    (refclk),
      .reset_n   (reset_n),
      .extlock   (extlock),
      .relock_req(relock_req),
      .pll_reset (pll_reset),
      .sys_rst_n (sys_rst_n),
      .lock_ok   (lock_ok),
      .lock_fail (lock_fail),
      .retry_cnt (retry_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // Release reset, raise extlock 10 cycles later, expect RUN 15 cycles after
   // the first edge that samples it (2 sync + 8 stable + 4 release + 1 reg).
   task automatic run_nominal(input string tag);
      int k;
      extlock = 1'b0;
      reset_n = 1'b1;
      k = 0;
      while (pll_reset && k < 20) begin
         k++;
         tick();
      end
      check_eq({tag, "_pll_reset_width"}, k, 4);
      repeat (6) tick();
      extlock = 1'b1;
      tick();
      k = 0;
      while (!sys_rst_n && k < 40) begin
         tick();
         k++;
      end
      check_eq({tag, "_lock_latency"}, k, 15);
      check_eq({tag, "_lock_ok"}, lock_ok, 1);
      check_eq({tag, "_pll_reset_run"}, pll_reset, 0);
      check_eq({tag, "_retry_run"}, retry_cnt, 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      extlock    = 1'b0;
      relock_req = 1'b0;
      repeat (3) tick();
      check_eq("rst_pll_reset", pll_reset, 1);
      check_eq("rst_sys_rst_n", sys_rst_n, 0);
      check_eq("rst_lock_ok", lock_ok, 0);
      check_eq("rst_lock_fail", lock_fail, 0);
      check_eq("rst_retry", retry_cnt, 0);

      run_nominal("nom");

      // Lock loss in RUN: extlock low for 2 cycles, sys_rst_n drops on the
      // third edge after the fall.
      extlock = 1'b0;
      tick();
      check_eq("loss_edge1_sys_rst_n", sys_rst_n, 1);
      tick();
      check_eq("loss_edge2_sys_rst_n", sys_rst_n, 1);
      extlock = 1'b1;
      tick();
      check_eq("loss_edge3_sys_rst_n", sys_rst_n, 0);
      check_eq("loss_edge3_lock_ok", lock_ok, 0);
      check_eq("loss_edge3_pll_reset", pll_reset, 1);
`ifdef PLL_LOCK_AUTO_RELOCK_EN
      check_eq("loss_auto_lock_fail", lock_fail, 0);
      check_eq("loss_auto_retry", retry_cnt, 0);
`else
      check_eq("loss_fail_lock_fail", lock_fail, 1);
      repeat (5) tick();
      check_eq("loss_fail_held", lock_fail, 1);
      check_eq("loss_fail_sys_rst_n", sys_rst_n, 0);
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check_eq("relock_from_fail_pll_reset", pll_reset, 1);
      check_eq("relock_from_fail_lock_fail", lock_fail, 0);
`endif
      // From RESET entry with lock present: 4 reset + 1 + 8 stable + 5 release.
      n = 0;
      while (!sys_rst_n && n < 60) begin
         tick();
         n++;
      end
      check_eq("resequence_latency", n, 18);

      // Timeout exhaustion: three 4-cycle pulses, each followed by 32 cycles
      // of WAIT_LOCK, retry stepping 0,1,2, then FAIL.
      extlock    = 1'b0;
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check_eq("relock_pll_reset_latency", pll_reset, 1);
      for (int a = 0; a < 3; a++) begin
         check_eq("tmo_retry", retry_cnt, a);
         check_eq("tmo_no_fail_yet", lock_fail, 0);
         n = 0;
         while (pll_reset && n < 20) begin
            n++;
            tick();
         end
         check_eq("tmo_pulse_width", n, 4);
         n = 0;
         while (!pll_reset && n < 100) begin
            tick();
            n++;
         end
         check_eq("tmo_wait_len", n, 32);
      end
      check_eq("tmo_fail_lock_fail", lock_fail, 1);
      check_eq("tmo_fail_retry", retry_cnt, 2);
      check_eq("tmo_fail_sys_rst_n", sys_rst_n, 0);
      repeat (8) tick();
      check_eq("tmo_fail_held", lock_fail, 1);
      check_eq("tmo_fail_pll_reset_held", pll_reset, 1);

      // Glitchy lock: high 6, low 1, high onward. The first run is rejected;
      // RELEASE follows the second run and RUN is reached 16 edges after the
      // low sample (2 sync + 1 clear + 8 stable + 5 release).
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check_eq("glitch_retry_cleared", retry_cnt, 0);
      repeat (4) tick();
      check_eq("glitch_in_wait", pll_reset, 0);
      extlock = 1'b1;
      repeat (6) tick();
      extlock = 1'b0;
      tick();
      extlock = 1'b1;
      n = 0;
      while (!sys_rst_n && n < 40) begin
         tick();
         n++;
      end
      check_eq("glitch_latency", n, 16);
      check_eq("glitch_retry", retry_cnt, 0);
      check_eq("glitch_lock_ok", lock_ok, 1);

      // Priority: relock_req lands on the third timeout (retry_cnt=2).
      // RESET at edge 1, timeouts at edges 37, 73, 109.
      extlock    = 1'b0;
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      repeat (107) tick();
      check_eq("prio_retry_before", retry_cnt, 2);
      check_eq("prio_wait_before", pll_reset, 0);
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check_eq("prio_lock_fail", lock_fail, 0);
      check_eq("prio_retry_after", retry_cnt, 0);
      check_eq("prio_pll_reset", pll_reset, 1);
      repeat (4) tick();
      check_eq("prio_reset_ends", pll_reset, 0);

      // Back to RUN from WAIT_LOCK: 2 sync + 8 stable + 5 release + 1.
      extlock = 1'b1;
      n = 0;
      while (!sys_rst_n && n < 60) begin
         tick();
         n++;
      end
      check_eq("rerun_latency", n, 16);

      // Async reset in the middle of a RUN cycle, no clock edge in between.
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_sys_rst_n", sys_rst_n, 0);
      check_eq("async_pll_reset", pll_reset, 1);
      check_eq("async_lock_ok", lock_ok, 0);
      extlock = 1'b0;
      repeat (3) tick();
      check_eq("async_retry", retry_cnt, 0);
      check_eq("async_lock_fail", lock_fail, 0);
      run_nominal("after_async");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
